// File: rtl/deepfifo_sched_pkg.sv
// Shared types for the deepfifo AXI scheduler: write/read FSM state encodings
// and the owner-index width helper.
package deepfifo_sched_pkg;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_BURST = 2'd1,
    W_RESP  = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } r_state_e;

  // Width of a binary channel index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/deepfifo_rr_pick.sv
// Combinational round-robin picker: scans from last+1 (mod S) and returns the
// first requesting channel as one-hot, binary index and an any-request flag.
module deepfifo_rr_pick
  import deepfifo_sched_pkg::*;
#(
  parameter int S  = 8,
  parameter int IW = idx_w(S)
) (
  input  logic [S-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [S-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int c;
    logic [IW-1:0] cand;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    c    = 0;
    cand = '0;
    for (int k = 1; k <= S; k++) begin
      c    = (int'(last) + k) % S;
      cand = IW'(c);
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/deepfifo_axi_sched.sv
// Shares one AXI4 master port among S deepfifo channels with independent
// round-robin write and read schedulers. Define DEEPFIFO_SCHED_WDT_EN to add
// per-path watchdogs that abort a stuck transaction and latch wdt_err.
module deepfifo_axi_sched
  import deepfifo_sched_pkg::*;
#(
  parameter int S          = 8,
  parameter int WDT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 sys_rst,
  input  logic [S-1:0]         aw_req,
  input  logic [S-1:0]         ar_req,
  input  logic                 aw_hs,
  input  logic                 w_last_hs,
  input  logic                 b_hs,
  input  logic                 ar_hs,
  input  logic                 r_last_hs,
  output logic [S-1:0]         wr_gnt,
  output logic [S-1:0]         rd_gnt,
  output logic [$clog2(S)-1:0] wr_idx,
  output logic [$clog2(S)-1:0] rd_idx,
  output logic                 wdt_err
);

  localparam int IW = idx_w(S);

  if (S < 2 || WDT_CYCLES < 1) begin : g_bad_cfg
    $error("deepfifo_axi_sched: S must be >= 2 and WDT_CYCLES >= 1");
  end

  w_state_e      w_state_q, w_state_d;
  logic [S-1:0]  wr_gnt_q, wr_gnt_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] wr_last_q, wr_last_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;

  r_state_e      r_state_q, r_state_d;
  logic [S-1:0]  rd_gnt_q, rd_gnt_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [IW-1:0] rd_last_q, rd_last_d;

  logic [S-1:0]  wr_pick_gnt, rd_pick_gnt;
  logic [IW-1:0] wr_pick_idx, rd_pick_idx;
  logic          wr_pick_any, rd_pick_any;

`ifdef DEEPFIFO_SCHED_WDT_EN
  localparam int CW = $clog2(WDT_CYCLES + 1);
  logic [CW-1:0] wr_wdt_q, wr_wdt_d;
  logic [CW-1:0] rd_wdt_q, rd_wdt_d;
  logic          wr_wdt_fire, rd_wdt_fire;
  logic          wdt_err_q, wdt_err_d;
`endif

  deepfifo_rr_pick #(.S(S), .IW(IW)) u_wr_pick (
    .req  (aw_req),
    .last (wr_last_q),
    .gnt  (wr_pick_gnt),
    .idx  (wr_pick_idx),
    .any  (wr_pick_any)
  );

  deepfifo_rr_pick #(.S(S), .IW(IW)) u_rd_pick (
    .req  (ar_req),
    .last (rd_last_q),
    .gnt  (rd_pick_gnt),
    .idx  (rd_pick_idx),
    .any  (rd_pick_any)
  );

  // Write path: AW and last-W may complete in any order before B is accepted.
  always_comb begin
    w_state_d = w_state_q;
    wr_gnt_d  = wr_gnt_q;
    wr_idx_d  = wr_idx_q;
    wr_last_d = wr_last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
`ifdef DEEPFIFO_SCHED_WDT_EN
    wr_wdt_d    = '0;
    wr_wdt_fire = 1'b0;
`endif
    case (w_state_q)
      W_IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (wr_pick_any) begin
          w_state_d = W_BURST;
          wr_gnt_d  = wr_pick_gnt;
          wr_idx_d  = wr_pick_idx;
          wr_last_d = wr_pick_idx;
        end
      end
      W_BURST: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_last_hs;
        if (aw_done_d && w_done_d) begin
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (b_hs) begin
          w_state_d = W_IDLE;
          wr_gnt_d  = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        wr_gnt_d  = '0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end
    endcase
`ifdef DEEPFIFO_SCHED_WDT_EN
    if (w_state_q != W_IDLE) begin
      if (wr_wdt_q == CW'(WDT_CYCLES - 1)) begin
        w_state_d   = W_IDLE;
        wr_gnt_d    = '0;
        aw_done_d   = 1'b0;
        w_done_d    = 1'b0;
        wr_wdt_fire = 1'b1;
      end else begin
        wr_wdt_d = wr_wdt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      w_state_q <= W_IDLE;
      wr_gnt_q  <= '0;
      wr_idx_q  <= '0;
      wr_last_q <= IW'(S - 1);
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      wr_gnt_q  <= wr_gnt_d;
      wr_idx_q  <= wr_idx_d;
      wr_last_q <= wr_last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Read path: address handshake first, then the last data beat releases.
  always_comb begin
    r_state_d = r_state_q;
    rd_gnt_d  = rd_gnt_q;
    rd_idx_d  = rd_idx_q;
    rd_last_d = rd_last_q;
`ifdef DEEPFIFO_SCHED_WDT_EN
    rd_wdt_d    = '0;
    rd_wdt_fire = 1'b0;
`endif
    case (r_state_q)
      R_IDLE: begin
        if (rd_pick_any) begin
          r_state_d = R_ADDR;
          rd_gnt_d  = rd_pick_gnt;
          rd_idx_d  = rd_pick_idx;
          rd_last_d = rd_pick_idx;
        end
      end
      R_ADDR: begin
        if (ar_hs) begin
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (r_last_hs) begin
          r_state_d = R_IDLE;
          rd_gnt_d  = '0;
        end
      end
      default: begin
        r_state_d = R_IDLE;
        rd_gnt_d  = '0;
      end
    endcase
`ifdef DEEPFIFO_SCHED_WDT_EN
    if (r_state_q != R_IDLE) begin
      if (rd_wdt_q == CW'(WDT_CYCLES - 1)) begin
        r_state_d   = R_IDLE;
        rd_gnt_d    = '0;
        rd_wdt_fire = 1'b1;
      end else begin
        rd_wdt_d = rd_wdt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state_q <= R_IDLE;
      rd_gnt_q  <= '0;
      rd_idx_q  <= '0;
      rd_last_q <= IW'(S - 1);
    end else begin
      r_state_q <= r_state_d;
      rd_gnt_q  <= rd_gnt_d;
      rd_idx_q  <= rd_idx_d;
      rd_last_q <= rd_last_d;
    end
  end

`ifdef DEEPFIFO_SCHED_WDT_EN
  always_comb begin
    wdt_err_d = wdt_err_q | wr_wdt_fire | rd_wdt_fire;
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_wdt_q  <= '0;
      rd_wdt_q  <= '0;
      wdt_err_q <= 1'b0;
    end else begin
      wr_wdt_q  <= wr_wdt_d;
      rd_wdt_q  <= rd_wdt_d;
      wdt_err_q <= wdt_err_d;
    end
  end

  assign wdt_err = wdt_err_q;
`else
  assign wdt_err = 1'b0;
`endif

  assign wr_gnt = wr_gnt_q;
  assign rd_gnt = rd_gnt_q;
  assign wr_idx = wr_idx_q;
  assign rd_idx = rd_idx_q;

endmodule

// File: tb/tb_deepfifo_axi_sched.sv
// Self-checking bench for deepfifo_axi_sched (S=8, WDT_CYCLES=16); the watchdog
// scenario runs when DEEPFIFO_SCHED_WDT_EN is defined.
module tb_deepfifo_axi_sched;

  localparam int S = 8;

  logic       clk;
  logic       sys_rst;
  logic [7:0] aw_req, ar_req;
  logic       aw_hs, w_last_hs, b_hs, ar_hs, r_last_hs;
  logic [7:0] wr_gnt, rd_gnt;
  logic [2:0] wr_idx, rd_idx;
  logic       wdt_err;

  int errors = 0;
  int checks = 0;
  int wr_last_m = S - 1;
  int rd_last_m = S - 1;

  deepfifo_axi_sched #(.S(S), .WDT_CYCLES(16)) dut (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .aw_req    (aw_req),
    .ar_req    (ar_req),
    .aw_hs     (aw_hs),
    .w_last_hs (w_last_hs),
    .b_hs      (b_hs),
    .ar_hs     (ar_hs),
    .r_last_hs (r_last_hs),
    .wr_gnt    (wr_gnt),
    .rd_gnt    (rd_gnt),
    .wr_idx    (wr_idx),
    .rd_idx    (rd_idx),
    .wdt_err   (wdt_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  // Reference rule: the first requester strictly after the previous winner, wrapping.
  function automatic int rr_next(input logic [7:0] m, input int last);
    for (int k = 1; k <= S; k++) begin
      if (m[(last + k) % S]) return (last + k) % S;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    aw_req = '0; ar_req = '0;
    aw_hs = 0; w_last_hs = 0; b_hs = 0; ar_hs = 0; r_last_hs = 0;
    tick();
    tick();
    sys_rst = 1'b0;
    wr_last_m = S - 1;
    rd_last_m = S - 1;
  endtask

  // One complete write transaction for request mask m; hold keeps aw_req asserted.
  task automatic wr_burst(input logic [7:0] m, input bit hold);
    int ei, a, b, mx, nw;
    logic [7:0] eg;
    ei = rr_next(m, wr_last_m);
    eg = 8'h01 << ei;
    aw_req = m;
    tick();
    checks++;
    if (wr_gnt !== eg || wr_idx !== 3'(ei)) begin
      errors++;
      $display("FAIL wr_grant: got gnt=%h idx=%0d, want gnt=%h idx=%0d (req=%h)", wr_gnt, wr_idx, eg, ei, m);
    end
    wr_last_m = ei;
    if (!hold) aw_req = '0;
    a = $urandom_range(0, 3);
    b = $urandom_range(0, 3);
    mx = (a > b) ? a : b;
    for (int t = 0; t <= mx; t++) begin
      aw_hs = (t == a);
      w_last_hs = (t == b);
      b_hs = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (wr_gnt !== eg) begin
        errors++;
        $display("FAIL wr_hold_burst: got gnt=%h, want %h (t=%0d aw@%0d w@%0d)", wr_gnt, eg, t, a, b);
      end
    end
    aw_hs = 0; w_last_hs = 0; b_hs = 0;
    nw = $urandom_range(0, 2);
    for (int t = 0; t < nw; t++) begin
      tick();
      checks++;
      if (wr_gnt !== eg) begin
        errors++;
        $display("FAIL wr_hold_resp: got gnt=%h, want %h", wr_gnt, eg);
      end
    end
    b_hs = 1;
    tick();
    b_hs = 0;
    checks++;
    if (wr_gnt !== 8'h00 || wr_idx !== 3'(ei)) begin
      errors++;
      $display("FAIL wr_release: got gnt=%h idx=%0d, want gnt=00 idx=%0d", wr_gnt, wr_idx, ei);
    end
  endtask

  task automatic rd_burst(input logic [7:0] m);
    int ei, n;
    logic [7:0] eg;
    ei = rr_next(m, rd_last_m);
    eg = 8'h01 << ei;
    ar_req = m;
    tick();
    checks++;
    if (rd_gnt !== eg || rd_idx !== 3'(ei)) begin
      errors++;
      $display("FAIL rd_grant: got gnt=%h idx=%0d, want gnt=%h idx=%0d (req=%h)", rd_gnt, rd_idx, eg, ei, m);
    end
    rd_last_m = ei;
    ar_req = '0;
    n = $urandom_range(0, 2);
    for (int t = 0; t < n; t++) begin
      r_last_hs = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (rd_gnt !== eg) begin
        errors++;
        $display("FAIL rd_hold_addr: got gnt=%h, want %h", rd_gnt, eg);
      end
    end
    r_last_hs = 0;
    ar_hs = 1;
    tick();
    ar_hs = 0;
    checks++;
    if (rd_gnt !== eg) begin
      errors++;
      $display("FAIL rd_hold_data: got gnt=%h, want %h", rd_gnt, eg);
    end
    repeat ($urandom_range(0, 2)) tick();
    r_last_hs = 1;
    tick();
    r_last_hs = 0;
    checks++;
    if (rd_gnt !== 8'h00 || rd_idx !== 3'(ei)) begin
      errors++;
      $display("FAIL rd_release: got gnt=%h idx=%0d, want gnt=00 idx=%0d", rd_gnt, rd_idx, ei);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    aw_req = 8'hFF; ar_req = 8'hFF;
    aw_hs = 0; w_last_hs = 0; b_hs = 0; ar_hs = 0; r_last_hs = 0;
    tick();
    tick();
    checks++;
    if (wr_gnt !== 8'h00 || rd_gnt !== 8'h00 || wr_idx !== 3'd0 || rd_idx !== 3'd0 || wdt_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got wr=%h rd=%h wi=%0d ri=%0d wdt=%b, want all zero", wr_gnt, rd_gnt, wr_idx, rd_idx, wdt_err);
    end
    aw_req = '0; ar_req = '0;
    sys_rst = 1'b0;
    tick();
    checks++;
    if (wr_gnt !== 8'h00 || rd_gnt !== 8'h00) begin
      errors++;
      $display("FAIL reset_idle: got wr=%h rd=%h, want 00 00", wr_gnt, rd_gnt);
    end
    wr_last_m = S - 1;
    rd_last_m = S - 1;
  endtask

  task automatic test_wrap_priority();
    do_reset();
    wr_burst(8'h81, 1'b1);
    wr_burst(8'h81, 1'b0);
    checks++;
    if (wr_idx !== 3'd7) begin
      errors++;
      $display("FAIL wrap_second_owner: got idx=%0d, want 7", wr_idx);
    end
  endtask

  task automatic test_w_before_aw();
    do_reset();
    aw_req = 8'h08;
    tick();
    aw_req = '0;
    checks++;
    if (wr_gnt !== 8'h08) begin
      errors++;
      $display("FAIL wfirst_grant: got %h, want 08", wr_gnt);
    end
    w_last_hs = 1;
    tick();
    w_last_hs = 0;
    b_hs = 1;
    tick();
    b_hs = 0;
    checks++;
    if (wr_gnt !== 8'h08) begin
      errors++;
      $display("FAIL wfirst_early_b: got %h, want 08", wr_gnt);
    end
    aw_hs = 1;
    tick();
    aw_hs = 0;
    tick();
    checks++;
    if (wr_gnt !== 8'h08) begin
      errors++;
      $display("FAIL wfirst_resp_wait: got %h, want 08", wr_gnt);
    end
    b_hs = 1;
    tick();
    b_hs = 0;
    checks++;
    if (wr_gnt !== 8'h00) begin
      errors++;
      $display("FAIL wfirst_release: got %h, want 00", wr_gnt);
    end
    wr_last_m = 3;
  endtask

  task automatic test_concurrent();
    do_reset();
    aw_req = 8'h04; ar_req = 8'h04;
    tick();
    aw_req = '0; ar_req = '0;
    checks++;
    if (wr_gnt !== 8'h04 || rd_gnt !== 8'h04) begin
      errors++;
      $display("FAIL conc_grant: got wr=%h rd=%h, want 04 04", wr_gnt, rd_gnt);
    end
    ar_hs = 1;
    tick();
    ar_hs = 0;
    r_last_hs = 1;
    tick();
    r_last_hs = 0;
    checks++;
    if (rd_gnt !== 8'h00 || wr_gnt !== 8'h04) begin
      errors++;
      $display("FAIL conc_rd_release: got wr=%h rd=%h, want 04 00", wr_gnt, rd_gnt);
    end
    aw_hs = 1; w_last_hs = 1;
    tick();
    aw_hs = 0; w_last_hs = 0;
    b_hs = 1;
    tick();
    b_hs = 0;
    checks++;
    if (wr_gnt !== 8'h00 || rd_gnt !== 8'h00) begin
      errors++;
      $display("FAIL conc_wr_release: got wr=%h rd=%h, want 00 00", wr_gnt, rd_gnt);
    end
    wr_last_m = 2;
    rd_last_m = 2;
  endtask

  task automatic test_rr_sweep();
    int cnt [8];
    do_reset();
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    for (int k = 0; k < 16; k++) begin
      wr_burst(8'hFF, 1'b1);
      checks++;
      if (wr_idx !== 3'(k % 8)) begin
        errors++;
        $display("FAIL sweep_order: burst %0d got idx=%0d, want %0d", k, wr_idx, k % 8);
      end
      cnt[wr_idx]++;
    end
    aw_req = '0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cnt[i] != 2) begin
        errors++;
        $display("FAIL sweep_count: channel %0d granted %0d times, want 2", i, cnt[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] m;
    for (int i = 0; i < 12; i++) begin
      m = 8'($urandom_range(1, 255));
      wr_burst(m, 1'b0);
      m = 8'($urandom_range(1, 255));
      rd_burst(m);
    end
  endtask

  task automatic test_reset_mid();
    aw_req = 8'h02;
    tick();
    aw_req = '0;
    aw_hs = 1; w_last_hs = 1;
    tick();
    aw_hs = 0; w_last_hs = 0;
    checks++;
    if (wr_gnt !== 8'h02) begin
      errors++;
      $display("FAIL rstmid_pre: got %h, want 02", wr_gnt);
    end
    #2 sys_rst = 1'b1;
    #1;
    checks++;
    if (wr_gnt !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_async_drop: got %h, want 00", wr_gnt);
    end
    tick();
    sys_rst = 1'b0;
    b_hs = 1;
    tick();
    b_hs = 0;
    tick();
    checks++;
    if (wr_gnt !== 8'h00 || wr_idx !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_stale_b: got gnt=%h idx=%0d, want 00 0", wr_gnt, wr_idx);
    end
    wr_last_m = S - 1;
    rd_last_m = S - 1;
    wr_burst(8'h81, 1'b0);
  endtask

  task automatic test_stall();
    do_reset();
    aw_req = 8'h10;
    tick();
    aw_req = '0;
`ifdef DEEPFIFO_SCHED_WDT_EN
    repeat (15) tick();
    checks++;
    if (wr_gnt !== 8'h10 || wdt_err !== 1'b0) begin
      errors++;
      $display("FAIL wdt_before_limit: got gnt=%h wdt=%b, want 10 0", wr_gnt, wdt_err);
    end
    tick();
    checks++;
    if (wr_gnt !== 8'h00 || wdt_err !== 1'b1) begin
      errors++;
      $display("FAIL wdt_abort: got gnt=%h wdt=%b, want 00 1", wr_gnt, wdt_err);
    end
    repeat (5) tick();
    checks++;
    if (wdt_err !== 1'b1) begin
      errors++;
      $display("FAIL wdt_sticky: got %b, want 1", wdt_err);
    end
    do_reset();
    checks++;
    if (wdt_err !== 1'b0) begin
      errors++;
      $display("FAIL wdt_reset_clear: got %b, want 0", wdt_err);
    end
`else
    repeat (40) tick();
    checks++;
    if (wr_gnt !== 8'h10 || wdt_err !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold: got gnt=%h wdt=%b, want 10 0", wr_gnt, wdt_err);
    end
    aw_hs = 1; w_last_hs = 1;
    tick();
    aw_hs = 0; w_last_hs = 0;
    b_hs = 1;
    tick();
    b_hs = 0;
    checks++;
    if (wr_gnt !== 8'h00) begin
      errors++;
      $display("FAIL stall_release: got %h, want 00", wr_gnt);
    end
    wr_last_m = 4;
`endif
  endtask

  initial begin
    test_reset();
    test_wrap_priority();
    test_w_before_aw();
    test_concurrent();
    test_rr_sweep();
    test_random();
    test_reset_mid();
    test_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/deepfifo_axi_sched.md
DEEPFIFO_AXI_SCHED -- requirements
Module: deepfifo_axi_sched

Interface
REQ-001 SHALL have parameter S, default 8, number of deepfifo requester channels sharing one AXI4 master port (S >= 2).
REQ-002 SHALL have parameter WDT_CYCLES, default 4096, watchdog limit in clk cycles; used only when DEEPFIFO_SCHED_WDT_EN is defined.
REQ-003 SHALL use one clock, clk; reset is sys_rst, asynchronous and active-high.
REQ-004 clk  input  1  AXI-domain clock; all logic on rising edge.
REQ-005 sys_rst  input  1  asynchronous active-high reset.
REQ-006 aw_req  input  S  per-channel write-burst request (channel awvalid).
REQ-007 ar_req  input  S  per-channel read-burst request (channel arvalid).
REQ-008 aw_hs  input  1  master AW handshake (m_awvalid & m_awready).
REQ-009 w_last_hs  input  1  master last-beat W handshake (m_wvalid & m_wready & m_wlast).
REQ-010 b_hs  input  1  master B handshake (m_bvalid & m_bready).
REQ-011 ar_hs  input  1  master AR handshake.
REQ-012 r_last_hs  input  1  master last-beat R handshake (m_rvalid & m_rready & m_rlast).
REQ-013 wr_gnt  output  S  one-hot write-path owner; the surrounding logic muxes AW/W/B with it.
REQ-014 rd_gnt  output  S  one-hot read-path owner; the surrounding logic muxes AR/R with it.
REQ-015 wr_idx, rd_idx  output  $clog2(S) each  binary index of the current owner.
REQ-016 wdt_err  output  1  sticky watchdog abort flag (tied 0 when the macro is undefined).

Function
REQ-017 Write and read schedulers SHALL be independent and able to hold grants to different or identical channels at the same time.
REQ-018 Write FSM states SHALL be W_IDLE, W_BURST and W_RESP.
REQ-019 W_IDLE->W_BURST when any aw_req bit is set; winner registered, so wr_gnt is asserted the cycle after the request is first seen.
REQ-020 W_BURST SHALL track flags aw_done and w_done, set by aw_hs and w_last_hs in either order or in the same cycle, and SHALL move to W_RESP once both are set.
REQ-021 W_RESP->W_IDLE on b_hs, with wr_gnt cleared in the same edge.
REQ-022 Read FSM states SHALL be R_IDLE, R_ADDR and R_DATA: R_IDLE->R_ADDR on any ar_req; R_ADDR->R_DATA on ar_hs; R_DATA->R_IDLE on r_last_hs.
REQ-023 Arbitration SHALL be round-robin: search starts at last winner+1 modulo S; after reset the last winner is S-1, so channel 0 has top priority.
REQ-024 A grant SHALL be held until its transaction completes, even if the request drops.
REQ-025 Handshake inputs SHALL be ignored in IDLE states; a b_hs before aw_done and w_done are both set SHALL be ignored.
REQ-026 Minimum IDLE dwell is one cycle, so back-to-back bursts from the same channel have a one-cycle gap.
REQ-027 wr_gnt and rd_gnt SHALL each be one-hot or zero at all times; wr_idx and rd_idx hold their value while the matching grant is zero.

Reset
REQ-028 On sys_rst: both FSMs go to IDLE; wr_gnt=0, rd_gnt=0, wr_idx=0, rd_idx=0, wdt_err=0; flags cleared; last winners set to S-1.
REQ-029 Reset mid-burst SHALL drop grants immediately; no completion is awaited.

Configuration
REQ-030 With DEEPFIFO_SCHED_WDT_EN defined, each FSM SHALL count cycles spent outside IDLE; on reaching WDT_CYCLES it SHALL force IDLE, clear its grant and set wdt_err until reset.
REQ-031 Without DEEPFIFO_SCHED_WDT_EN, no counters SHALL be built, wdt_err SHALL be constant 0 and FSMs SHALL wait indefinitely.

Structure
REQ-032 Package deepfifo_sched_pkg SHALL hold the write and read state enums and the index-width constant function.
REQ-033 Sub-module deepfifo_rr_pick (combinational round-robin picker: req, last index -> one-hot, index, any) SHALL be instantiated twice.

Verification
REQ-034 aw_req=8'h81 after reset -> wr_gnt=8'h01 next cycle; after that burst's b_hs and one IDLE cycle -> wr_gnt=8'h80.
REQ-035 w_last_hs two cycles before aw_hs -> state stays W_BURST until aw_hs, then W_RESP; b_hs -> wr_gnt=0.
REQ-036 ar_req=8'h04 and aw_req=8'h04 in the same cycle -> rd_gnt=wr_gnt=8'h04 at once; each path releases on its own completion.
REQ-037 aw_req=8'hFF held for 16 bursts -> grant order 0..7,0..7; each channel granted exactly twice.
REQ-038 sys_rst pulsed in W_RESP -> wr_gnt=0 on the asserting edge; the stale b_hs that follows is ignored.
REQ-039 WDT_EN, WDT_CYCLES=16, aw_hs withheld -> wr_gnt cleared and wdt_err=1 after 16 cycles; wdt_err stays 1 until reset.
